ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter, the opposite direction of the existing PS/2 keyboard receive path.
- Sends one command byte to the keyboard: 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives the shared open-drain ps2_clk/ps2_data lines via output enables, checks the device ACK, and reports done/error.
- Asserts rx_inhibit while active so the receive path ignores self-generated traffic.

---
 rtl/ps2_host_tx_pkg.sv | 31 +++
 rtl/ps2_line_sync.sv | 41 ++++
 rtl/ps2_host_tx.sv | 174 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-side paths: transmitter state encoding,
// keyboard command bytes, scan codes used by the cursor logic, and frame building.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_IDLE_WAIT = 3'd5
  } tx_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  localparam logic [7:0] KEY_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] KEY_BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] KEY_UP           = 8'h75;
  localparam logic [7:0] KEY_DOWN         = 8'h72;
  localparam logic [7:0] KEY_LEFT         = 8'h6B;
  localparam logic [7:0] KEY_RIGHT        = 8'h74;

  // Bits after the start bit, LSB first: data[7:0], odd parity, stop.
  function automatic logic [9:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the raw ps2_clk/ps2_data levels plus falling-edge
// detection on the synchronized values. Also used by the keyboard receive path.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_sync,
  output logic o_data_sync,
  output logic o_clk_fall,
  output logic o_data_fall
);

  logic r_clk_meta, r_clk_sync, r_clk_prev;
  logic r_data_meta, r_data_sync, r_data_prev;

  // Reset to the idle (released, pulled-up) level so no edge appears out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
      r_data_prev <= 1'b1;
    end else begin
      r_clk_meta  <= i_ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= i_ps2_data;
      r_data_sync <= r_data_meta;
      r_data_prev <= r_data_sync;
    end
  end

  assign o_clk_sync  = r_clk_sync;
  assign o_data_sync = r_data_sync;
  assign o_clk_fall  = r_clk_prev & ~r_clk_sync;
  assign o_data_fall = r_data_prev & ~r_data_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts out one command byte on device clock edges, checks the ACK and reports.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [2:0] o_dbg_state
);

  // Handshake: tx_start is sampled only while busy=0; every accepted request ends
  // in exactly one done pulse (ack_err/timeout valid with it) unless reset intervenes.

  localparam int INH_W    = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  // The REQ cycle is the last of the INHIBIT_CYCLES clock-low cycles.
  localparam int INH_LAST = (INHIBIT_CYCLES > 1) ? INHIBIT_CYCLES - 2 : 0;
  localparam int TMO_LAST = TIMEOUT_CYCLES - 1;

  tx_state_t        r_state, w_nxt_state;
  logic [INH_W-1:0] r_inh_cnt, w_nxt_inh_cnt;
  logic [TMO_W-1:0] r_tmo_cnt, w_nxt_tmo_cnt;
  logic [3:0]       r_bitcnt, w_nxt_bitcnt;
  logic [9:0]       r_frame, w_nxt_frame;
  logic             r_clk_oe, w_nxt_clk_oe;
  logic             r_data_oe, w_nxt_data_oe;
  logic             r_ack_err, w_nxt_ack_err;
  logic             r_timeout, w_nxt_timeout;
  logic             r_done, w_nxt_done;

  logic w_clk_s, w_data_s, w_clk_fall, w_data_fall;
  logic w_unused_data_fall;

  ps2_line_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .i_ps2_clk   (ps2_clk_in),
    .i_ps2_data  (ps2_data_in),
    .o_clk_sync  (w_clk_s),
    .o_data_sync (w_data_s),
    .o_clk_fall  (w_clk_fall),
    .o_data_fall (w_data_fall)
  );

  assign w_unused_data_fall = w_data_fall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_inh_cnt <= '0;
      r_tmo_cnt <= '0;
      r_bitcnt  <= '0;
      r_frame   <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_ack_err <= 1'b0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_inh_cnt <= w_nxt_inh_cnt;
      r_tmo_cnt <= w_nxt_tmo_cnt;
      r_bitcnt  <= w_nxt_bitcnt;
      r_frame   <= w_nxt_frame;
      r_clk_oe  <= w_nxt_clk_oe;
      r_data_oe <= w_nxt_data_oe;
      r_ack_err <= w_nxt_ack_err;
      r_timeout <= w_nxt_timeout;
      r_done    <= w_nxt_done;
    end
  end

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_inh_cnt = r_inh_cnt;
    w_nxt_tmo_cnt = r_tmo_cnt;
    w_nxt_bitcnt  = r_bitcnt;
    w_nxt_frame   = r_frame;
    w_nxt_clk_oe  = r_clk_oe;
    w_nxt_data_oe = r_data_oe;
    w_nxt_ack_err = r_ack_err;
    w_nxt_timeout = r_timeout;
    w_nxt_done    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (tx_start) begin
          w_nxt_frame   = build_frame(tx_data);
          w_nxt_ack_err = 1'b0;
          w_nxt_timeout = 1'b0;
          w_nxt_clk_oe  = 1'b1;
          w_nxt_inh_cnt = '0;
          w_nxt_state   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        w_nxt_inh_cnt = r_inh_cnt + INH_W'(1);
        if (r_inh_cnt == INH_W'(INH_LAST)) begin
          w_nxt_data_oe = 1'b1;
          w_nxt_state   = ST_REQ;
        end
      end

      ST_REQ: begin
        w_nxt_clk_oe  = 1'b0;
        w_nxt_bitcnt  = '0;
        w_nxt_tmo_cnt = '0;
        w_nxt_state   = ST_SEND;
      end

      ST_SEND, ST_ACK, ST_IDLE_WAIT: begin
        w_nxt_tmo_cnt = r_tmo_cnt + TMO_W'(1);
        // Timeout has priority over any edge seen in the same cycle.
        if (r_tmo_cnt == TMO_W'(TMO_LAST)) begin
          w_nxt_clk_oe  = 1'b0;
          w_nxt_data_oe = 1'b0;
          w_nxt_timeout = 1'b1;
          w_nxt_done    = 1'b1;
          w_nxt_state   = ST_IDLE;
        end else if (r_state == ST_SEND) begin
          if (w_clk_fall) begin
            w_nxt_data_oe = ~r_frame[0];
            w_nxt_frame   = {1'b0, r_frame[9:1]};
            w_nxt_bitcnt  = r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd9) begin
              w_nxt_state = ST_ACK;
            end
          end
        end else if (r_state == ST_ACK) begin
          if (w_clk_fall) begin
            w_nxt_ack_err = w_data_s;
            w_nxt_state   = ST_IDLE_WAIT;
          end
        end else begin
          if (w_clk_s && w_data_s) begin
            w_nxt_done  = 1'b1;
            w_nxt_state = ST_IDLE;
          end
        end
      end

      default: begin
        w_nxt_clk_oe  = 1'b0;
        w_nxt_data_oe = 1'b0;
        w_nxt_state   = ST_IDLE;
      end
    endcase
  end

  assign busy        = (r_state != ST_IDLE);
  assign rx_inhibit  = busy;
  assign done        = r_done;
  assign ack_err     = r_ack_err;
  assign timeout     = r_timeout;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus model and a PS/2 device
// model that clocks frames, samples host bits on rising clock and optionally ACKs.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 2000;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  wire        busy, done, ack_err, timeout, rx_inhibit;
  wire        ps2_clk_oe, ps2_data_oe;
  wire        ps2_clk_in, ps2_data_in;
  wire  [2:0] dbg_state;

  int checks = 0;
  int failures = 0;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout     (timeout),
    .rx_inhibit  (rx_inhibit),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Returns at the first negedge where the host has released the clock line.
  task automatic wait_release(output int clk_cycles, output int data_cycles, output bit ok);
    clk_cycles = 0;
    data_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ps2_clk_oe === 1'b0) begin
        ok = 1'b1;
        break;
      end
      clk_cycles++;
      if (ps2_data_oe === 1'b1) data_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic device_clock(input int n, input bit ack, output logic [9:0] bits);
    bits = '0;
    for (int e = 1; e <= n; e++) begin
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (e <= 10) bits[e-1] = ps2_data_in;
      dev_clk = 1'b1;
      if (e == 10 && ack) dev_data = 1'b0;
      if (e == 11) dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, ack_err, timeout, rx_inhibit, ps2_clk_oe, ps2_data_oe} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000000",
               {busy, done, ack_err, timeout, rx_inhibit, ps2_clk_oe, ps2_data_oe});
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d want=0", dbg_state);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) begin
      failures++;
      $display("FAIL idle_no_start got=%b want=000", {busy, ps2_clk_oe, ps2_data_oe});
    end
  endtask

  task automatic full_transfer(input string name, input logic [7:0] d, input bit ack,
                               input logic [9:0] exp_bits, input bit exp_err);
    int c, dc;
    bit ok;
    logic [9:0] bits;
    start_tx(d);
    wait_release(c, dc, ok);
    checks++;
    if (!ok || c != INH || dc != 1) begin
      failures++;
      $display("FAIL %s_inhibit released=%0d clk_low=%0d data_low=%0d want clk_low=%0d data_low=1",
               name, ok, c, dc, INH);
    end
    checks++;
    if (ps2_data_oe !== 1'b1 || rx_inhibit !== 1'b1) begin
      failures++;
      $display("FAIL %s_start_bit data_oe=%b rx_inhibit=%b want 1 1", name, ps2_data_oe, rx_inhibit);
    end
    device_clock(11, ack, bits);
    wait_done(100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_done no done pulse within 100 cycles", name);
    end
    checks++;
    if (bits !== exp_bits) begin
      failures++;
      $display("FAIL %s_bits got=%h want=%h", name, bits, exp_bits);
    end
    checks++;
    if (ack_err !== exp_err || timeout !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_status ack_err=%b timeout=%b busy=%b want %b 0 0",
               name, ack_err, timeout, busy, exp_err);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      failures++;
      $display("FAIL %s_after_done done=%b clk_oe=%b data_oe=%b want 0 0 0",
               name, done, ps2_clk_oe, ps2_data_oe);
    end
  endtask

  // 0xED -> data 1,0,1,1,0,1,1,1, parity 1, stop 1
  task automatic test_send_ed();
    full_transfer("send_ed", 8'hED, 1'b1, 10'h3ED, 1'b0);
  endtask

  task automatic test_no_ack();
    full_transfer("no_ack", 8'h00, 1'b0, 10'h300, 1'b1);
  endtask

  task automatic test_timeout();
    int c, dc, k;
    bit ok;
    start_tx(8'hFF);
    wait_release(c, dc, ok);
    checks++;
    if (!ok || c != INH) begin
      failures++;
      $display("FAIL timeout_inhibit released=%0d clk_low=%0d want %0d", ok, c, INH);
    end
    k = 0;
    while (done !== 1'b1 && k < TMO + 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != TMO) begin
      failures++;
      $display("FAIL timeout_latency got=%0d want=%0d", k, TMO);
    end
    checks++;
    if (timeout !== 1'b1 || ack_err !== 1'b0 || busy !== 1'b0 ||
        ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      failures++;
      $display("FAIL timeout_status timeout=%b ack_err=%b busy=%b clk_oe=%b data_oe=%b want 1 0 0 0 0",
               timeout, ack_err, busy, ps2_clk_oe, ps2_data_oe);
    end
  endtask

  // Device edge lands in the same cycle the timeout counter hits its terminal value.
  task automatic test_glitch();
    int c, dc;
    bit ok;
    start_tx(8'h00);
    wait_release(c, dc, ok);
    repeat (TMO - 3) @(negedge clk);
    dev_clk = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || timeout !== 1'b1 || ps2_data_oe !== 1'b0 || ps2_clk_oe !== 1'b0) begin
      failures++;
      $display("FAIL glitch_timeout done=%b timeout=%b data_oe=%b clk_oe=%b want 1 1 0 0",
               done, timeout, ps2_data_oe, ps2_clk_oe);
    end
    @(negedge clk);
    checks++;
    if (ps2_data_oe !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_after data_oe=%b busy=%b want 0 0", ps2_data_oe, busy);
    end
    dev_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int c, dc, n_done;
    bit ok;
    logic [9:0] bits;
    start_tx(8'h00);
    wait_release(c, dc, ok);
    device_clock(4, 1'b0, bits);
    repeat (2) @(negedge clk);
    checks++;
    if (ps2_data_oe !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre data_oe=%b busy=%b want 1 1", ps2_data_oe, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_release clk_oe=%b data_oe=%b busy=%b done=%b want 0 0 0 0",
               ps2_clk_oe, ps2_data_oe, busy, done);
    end
    rst = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      failures++;
      $display("FAIL reset_mid_no_done got=%0d pulses want=0", n_done);
    end
    full_transfer("after_reset_f4", 8'hF4, 1'b1, 10'h2F4, 1'b0);
  endtask

  task automatic test_back_to_back();
    int c, dc;
    bit ok;
    logic [9:0] bits;
    start_tx(8'h3C);
    wait_release(c, dc, ok);
    fork
      device_clock(11, 1'b1, bits);
      begin
        repeat (40) @(negedge clk);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || ps2_clk_oe !== 1'b0) begin
          failures++;
          $display("FAIL ignore_start busy=%b clk_oe=%b want 1 0", busy, ps2_clk_oe);
        end
      end
    join
    wait_done(100, ok);
    checks++;
    if (!ok || bits !== 10'h33C || ack_err !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start_frame done=%0d bits=%h ack_err=%b want 1 33c 0", ok, bits, ack_err);
    end
    tx_data  = 8'hF4;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ps2_clk_oe !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL start_in_done_cycle busy=%b clk_oe=%b done=%b want 1 1 0", busy, ps2_clk_oe, done);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_no_ack();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
